lc3_mem_arbiter: RTL

Two-requester memory arbiter and access sequencer placed between the LC-3 control FSM's memory handshake and the single-port system memory. The first requester is the CPU (mio_en / rw / r handshake). The second is a program loader or debug port with the same handshake. The block grants the shared memory to one requester at a time, drives the memory for a fixed number of cycles, captures read data, and returns the ready signal r to the owning requester.

---
 rtl/lc3_mem_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 25 ++
 rtl/lc3_mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_pkg.sv
// Shared encodings for the LC-3 two-requester memory arbiter.
package lc3_mem_pkg;

    // Arbiter FSM states; the value 3 is never entered.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Requester identities, used both as owner id and as round-robin history.
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

    // Direction of a memory access.
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    // Width of the per-access latency counter.
    localparam int CNT_W = 4;

endpackage : lc3_mem_pkg

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker.
// req_i[0] is the CPU, req_i[1] is the loader. On a tie the requester that
// did not win last time is chosen, so neither side can be starved.
module rr_arb2
    import lc3_mem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o,
    output logic       valid_o
);

    // Pick a winner from the current request vector and grant history.
    always_comb begin
        valid_o = |req_i;
        grant_o = OWN_CPU;
        case (req_i)
            2'b01:   grant_o = OWN_CPU;
            2'b10:   grant_o = OWN_LDR;
            2'b11:   grant_o = ~last_grant_i;
            default: grant_o = OWN_CPU;
        endcase
    end

endmodule : rr_arb2

// File: rtl/lc3_mem_arbiter.sv
// Two-requester arbiter and access sequencer in front of a single-port memory.
// A granted request is latched, the memory is driven for MEM_LATENCY cycles,
// read data is captured into the owner's rdata register, and the owner's
// ready flag is held until the owner drops its enable.
module lc3_mem_arbiter
    import lc3_mem_pkg::*;
#(
    parameter int MEM_LATENCY = 2,   // cycles mem_en is held, legal 1..15
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              i_Clk,
    input  logic              reset_,
    // CPU requester
    input  logic              cpu_mio_en,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_r,
    // Loader / debug requester
    input  logic              ldr_en,
    input  logic              ldr_rw,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_r,
    // Memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // Debug
    output logic              debug_owner,
    output logic [1:0]        debug_state
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_e            state_q,      state_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;
    logic              owner_q,      owner_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [DATA_W-1:0] wdata_q,      wdata_d;
    logic              rw_q,         rw_d;
    logic [DATA_W-1:0] cpu_rdata_q,  cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q,  ldr_rdata_d;

    logic              arb_grant;
    logic              arb_valid;
    logic              owner_en;

    rr_arb2 u_rr_arb2 (
        .req_i        ({ldr_en, cpu_mio_en}),
        .last_grant_i (last_grant_q),
        .grant_o      (arb_grant),
        .valid_o      (arb_valid)
    );

    // Enable of whichever requester currently owns the memory; DONE waits on it.
    assign owner_en = (owner_q == OWN_LDR) ? ldr_en : cpu_mio_en;

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge i_Clk or negedge reset_) begin
        if (!reset_) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_LDR;   // makes the CPU win the first tie
            addr_q       <= '0;
            wdata_q      <= '0;
            rw_q         <= RW_READ;
            cpu_rdata_q  <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rw_q         <= rw_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    // Next-state logic: grant in IDLE, count out the access, hold DONE until release.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rw_d         = rw_q;
        cpu_rdata_d  = cpu_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    owner_d      = arb_grant;
                    last_grant_d = arb_grant;
                    cnt_d        = CNT_LOAD;
                    state_d      = ST_ACCESS;
                    if (arb_grant == OWN_LDR) begin
                        addr_d  = ldr_addr;
                        wdata_d = ldr_wdata;
                        rw_d    = ldr_rw;
                    end else begin
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        rw_d    = cpu_rw;
                    end
                end
            end

            ST_ACCESS: begin
                // Requester inputs are deliberately ignored here; the latched
                // command runs to completion even if enable drops.
                if (cnt_q == '0) begin
                    if (rw_q == RW_READ) begin
                        if (owner_q == OWN_LDR) begin
                            ldr_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DONE: begin
                // Holding here while enable stays high prevents a requester
                // that keeps enable up after r from launching a duplicate access.
                if (!owner_en) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory and handshake outputs decode straight from the registered state,
    // so an asynchronous reset drops them without waiting for a clock edge.
    always_comb begin
        mem_en    = (state_q == ST_ACCESS);
        mem_we    = (state_q == ST_ACCESS) && (rw_q == RW_WRITE);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cpu_r     = (state_q == ST_DONE) && (owner_q == OWN_CPU);
        ldr_r     = (state_q == ST_DONE) && (owner_q == OWN_LDR);
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign ldr_rdata   = ldr_rdata_q;
    assign debug_owner = owner_q;
    assign debug_state = state_q;

endmodule : lc3_mem_arbiter
